// File: rtl/pipelined_csel_adder_pkg.sv
// Shared arithmetic helpers: stage count and add/sub mode encodings.
package pipelined_csel_adder_pkg;

    localparam logic CSEL_ADD = 1'b0;
    localparam logic CSEL_SUB = 1'b1;

    // Number of BLOCK_WIDTH slices (and pipeline stages) for a given operand width.
    function automatic int nblk(input int w, input int bw);
        return w / bw;
    endfunction

endpackage

// File: rtl/pipelined_csel_adder_csel_block.sv
// One carry-select slice: two ripple chains with fixed carry-in, muxed by the real carry.

module rca_carry_chain #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] s_o,
    output logic         co_o
);
    // Explicit bit-serial ripple; each select half is a plain carry chain.
    always_comb begin
        logic c;
        c   = cin_i;
        s_o = '0;
        for (int i = 0; i < W; i++) begin
            s_o[i] = a_i[i] ^ b_i[i] ^ c;
            c      = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
        end
        co_o = c;
    end
endmodule

module csel_block #(
    parameter int BLOCK_WIDTH = 8
) (
    input  logic [BLOCK_WIDTH-1:0] a_i,
    input  logic [BLOCK_WIDTH-1:0] b_i,
    input  logic                   sel_i,
    output logic [BLOCK_WIDTH-1:0] s_o,
    output logic                   co_o
);
    logic [BLOCK_WIDTH-1:0] s0, s1;
    logic                   c0, c1;

    rca_carry_chain #(.W(BLOCK_WIDTH)) u_rca0 (
        .a_i(a_i), .b_i(b_i), .cin_i(1'b0), .s_o(s0), .co_o(c0)
    );
    rca_carry_chain #(.W(BLOCK_WIDTH)) u_rca1 (
        .a_i(a_i), .b_i(b_i), .cin_i(1'b1), .s_o(s1), .co_o(c1)
    );

    // The late-arriving carry only drives the select, not the adders.
    assign s_o  = sel_i ? s1 : s0;
    assign co_o = sel_i ? c1 : c0;
endmodule

// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor: one BLOCK_WIDTH slice resolved per stage,
// valid/ready on both sides, bubbles collapse, synchronous flush.
module pipelined_csel_adder
    import pipelined_csel_adder_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int BLOCK_WIDTH = 8
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iClr,
    input  logic             iValid,
    output logic             oReady,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic             iC,
    input  logic             iSub,
    output logic             oValid,
    input  logic             iReady,
    output logic [WIDTH-1:0] oS,
    output logic             oC,
    output logic             oV
);
    localparam int NB  = nblk(WIDTH, BLOCK_WIDTH);
    localparam int BW  = BLOCK_WIDTH;
    localparam int MSB = WIDTH - 1;

    if (NB < 1 || (WIDTH % BLOCK_WIDTH) != 0) begin : g_bad_width
        $error("pipelined_csel_adder: WIDTH must be a nonzero multiple of BLOCK_WIDTH");
    end

    // Stage registers. a_q/b_q carry the operands forward; only the slices above
    // the already-resolved blocks matter downstream, the MSBs feed overflow.
    logic [NB-1:0]    vld_q;
    logic [WIDTH-1:0] a_q   [NB];
    logic [WIDTH-1:0] b_q   [NB];
    logic [WIDTH-1:0] sum_q [NB];
    logic [NB-1:0]    co_q;
    logic             v_q;

    // Per-stage combinational view: what each stage would capture this edge.
    logic [WIDTH-1:0] op_a   [NB];
    logic [WIDTH-1:0] op_b   [NB];
    logic [WIDTH-1:0] op_sum [NB];
    logic [WIDTH-1:0] sum_d  [NB];
    logic [NB-1:0]    op_c;
    logic [NB-1:0]    blk_c;
    logic [NB-1:0]    adv;
    logic [NB-1:0]    ld;
    logic             v_d;

    for (genvar k = 0; k < NB; k++) begin : g_stg
        logic [BW-1:0]    bs;
        logic [WIDTH-1:0] bs_ext;

        if (k == 0) begin : g_head
            assign op_a[k]   = iA;
            assign op_b[k]   = iB ^ {WIDTH{iSub == CSEL_SUB}};
            assign op_c[k]   = iC ^ (iSub == CSEL_SUB);
            assign op_sum[k] = '0;
        end else begin : g_body
            assign op_a[k]   = a_q[k-1];
            assign op_b[k]   = b_q[k-1];
            assign op_c[k]   = co_q[k-1];
            assign op_sum[k] = sum_q[k-1];
        end

        csel_block #(.BLOCK_WIDTH(BW)) u_blk (
            .a_i  (op_a[k][k*BW +: BW]),
            .b_i  (op_b[k][k*BW +: BW]),
            .sel_i(op_c[k]),
            .s_o  (bs),
            .co_o (blk_c[k])
        );

        // Unresolved sum bits are always zero, so OR-ing the new block in is exact.
        assign bs_ext   = WIDTH'(bs);
        assign sum_d[k] = op_sum[k] | (bs_ext << (k * BW));
    end

    assign v_d = (op_a[NB-1][MSB] == op_b[NB-1][MSB]) & (sum_d[NB-1][MSB] != op_a[NB-1][MSB]);

    // Advance chain, resolved from the output back: a stage moves when it is full
    // and its successor is empty or moving; the last stage moves on iReady.
    always_comb begin
        logic free;
        free = iReady;
        adv  = '0;
        ld   = '0;
        for (int k = NB - 1; k >= 0; k--) begin
            adv[k] = vld_q[k] & free;
            free   = !vld_q[k] | adv[k];
        end
        oReady = free;
        ld[0]  = iValid & free;
        for (int k = 1; k < NB; k++) begin
            ld[k] = adv[k-1];
        end
    end

    // Pipeline state: flush clears valids only, data regs keep their last contents.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            vld_q <= '0;
            co_q  <= '0;
            v_q   <= 1'b0;
            for (int k = 0; k < NB; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NB; k++) begin
                vld_q[k] <= !iClr & (ld[k] | (vld_q[k] & !adv[k]));
                if (ld[k] && !iClr) begin
                    a_q[k]   <= op_a[k];
                    b_q[k]   <= op_b[k];
                    sum_q[k] <= sum_d[k];
                    co_q[k]  <= blk_c[k];
                end
            end
            if (ld[NB-1] && !iClr) begin
                v_q <= v_d;
            end
        end
    end

    assign oValid = vld_q[NB-1];
    assign oS     = sum_q[NB-1];
    assign oC     = co_q[NB-1];
    assign oV     = v_q;

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Directed bench for pipelined_csel_adder: 32/8 and 8/8 configurations.
module tb_pipelined_csel_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, clr;
    logic        iv, ir, ci, sub, rdy, ov, co, vf;
    logic [31:0] a, b, s;
    logic        iv8, ir8, ci8, sub8, rdy8, ov8, co8, vf8;
    logic [7:0]  a8, b8, s8;

    pipelined_csel_adder #(.WIDTH(32), .BLOCK_WIDTH(8)) u_dut (
        .iClk(clk), .iRst_n(rst_n), .iClr(clr), .iValid(iv), .oReady(rdy),
        .iA(a), .iB(b), .iC(ci), .iSub(sub), .oValid(ov), .iReady(ir),
        .oS(s), .oC(co), .oV(vf)
    );

    pipelined_csel_adder #(.WIDTH(8), .BLOCK_WIDTH(8)) u_dut8 (
        .iClk(clk), .iRst_n(rst_n), .iClr(clr), .iValid(iv8), .oReady(rdy8),
        .iA(a8), .iB(b8), .iC(ci8), .iSub(sub8), .oValid(ov8), .iReady(ir8),
        .oS(s8), .oC(co8), .oV(vf8)
    );

    int          n_chk = 0, n_fail = 0;
    int          n_in = 0, n_out = 0, n_rlow = 0;
    logic        acc;
    logic [33:0] q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: {V, C, S} straight from the two's-complement definition.
    function automatic logic [33:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                          input logic mc, input logic msub);
        logic [31:0] bb;
        logic [32:0] r;
        logic        v;
        bb = msub ? ~mb : mb;
        r  = {1'b0, ma} + {1'b0, bb} + {32'd0, mc ^ msub};
        v  = (ma[31] == bb[31]) && (r[31] != ma[31]);
        return {v, r[32], r[31:0]};
    endfunction

    // One cycle of the 32-bit DUT: sample handshakes, score, step to next negedge.
    task automatic cyc();
        logic [33:0] e;
        #1;
        acc = iv && rdy && !clr;
        if (acc) begin
            q.push_back(model(a, b, ci, sub));
            n_in++;
        end
        if (iv && !rdy) n_rlow++;
        if (ov && ir) begin
            n_out++;
            chk("sb_pending", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("sb_res", {30'd0, vf, co, s}, {30'd0, e});
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        iv = 1'b0;
        ir = 1'b1;
        n  = 0;
        while ((q.size() != 0 || ov) && n < 30) begin
            cyc();
            n++;
        end
        chk("drain_left", 64'(q.size()), 64'd0);
    endtask

    // Single op from an empty pipe: latency plus hand-computed result.
    task automatic run1(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                        input logic tc, input logic tsub,
                        input logic [31:0] es, input logic ec, input logic ev);
        int lat;
        a = ta; b = tb; ci = tc; sub = tsub; iv = 1'b1; ir = 1'b1;
        cyc();
        iv  = 1'b0;
        lat = 1;
        while (!ov && lat < 20) begin
            cyc();
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'd4);
        chk({tag, "_s"}, 64'(s), 64'(es));
        chk({tag, "_c"}, 64'(co), 64'(ec));
        chk({tag, "_v"}, 64'(vf), 64'(ev));
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", n_chk);
        $fatal(1, "timeout");
    end

    initial begin
        int          in0, out0, rl0, gaps, stale;
        logic [31:0] hs;
        logic        have;

        rst_n = 1'b0; clr = 1'b0;
        iv = 1'b0; ir = 1'b1; a = '0; b = '0; ci = 1'b0; sub = 1'b0;
        iv8 = 1'b0; ir8 = 1'b1; a8 = '0; b8 = '0; ci8 = 1'b0; sub8 = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_ov", 64'(ov), 64'd0);
        chk("rst_s", 64'(s), 64'd0);
        chk("rst_c", 64'(co), 64'd0);
        chk("rst_v", 64'(vf), 64'd0);
        chk("rst_ov8", 64'(ov8), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_rdy", 64'(rdy), 64'd1);
        chk("rst_rdy8", 64'(rdy8), 64'd1);
        @(negedge clk);

        // NBLK=1: a single registered stage.
        a8 = 8'hFF; b8 = 8'h01; iv8 = 1'b1;
        @(posedge clk); @(negedge clk);
        iv8 = 1'b0;
        chk("w8_lat", 64'(ov8), 64'd1);
        chk("w8_s", 64'(s8), 64'h00);
        chk("w8_c", 64'(co8), 64'd1);
        chk("w8_v", 64'(vf8), 64'd0);
        a8 = 8'h7F; b8 = 8'h01; iv8 = 1'b1;
        @(posedge clk); @(negedge clk);
        iv8 = 1'b0;
        chk("w8b_s", 64'(s8), 64'h80);
        chk("w8b_v", 64'(vf8), 64'd1);
        @(posedge clk); @(negedge clk);
        chk("w8_empty", 64'(ov8), 64'd0);

        // Directed 32-bit vectors.
        run1("t1", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run1("t2a", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run1("t2b", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run1("t2c", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        run1("t2d", 32'h0000_00FF, 32'h0, 1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        run1("t2e", 32'd10, 32'd3, 1'b1, 1'b1, 32'd6, 1'b1, 1'b0);

        // Back-to-back stream.
        rl0 = n_rlow; out0 = n_out; gaps = 0;
        for (int i = 0; i < 100; i++) begin
            a = $urandom; b = $urandom;
            ci = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            iv = 1'b1;
            if (i >= 4 && !ov) gaps++;
            cyc();
        end
        drain();
        chk("t3_rdy_low", 64'(n_rlow - rl0), 64'd0);
        chk("t3_gaps", 64'(gaps), 64'd0);
        chk("t3_count", 64'(n_out - out0), 64'd100);

        // Backpressure: 4 ops fill the pipe, output holds, then everything drains in order.
        in0 = n_in; out0 = n_out; have = 1'b0; hs = '0;
        a = $urandom; b = $urandom; ci = 1'b0; sub = 1'b0;
        ir = 1'b0; iv = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (ov) begin
                if (!have) begin
                    hs = s;
                    have = 1'b1;
                end else begin
                    chk("t4_hold", 64'(s), 64'(hs));
                end
            end
            cyc();
            if (acc) begin a = $urandom; b = $urandom; sub = ~sub; end
        end
        chk("t4_buffered", 64'(n_in - in0), 64'd4);
        chk("t4_rdy", 64'(rdy), 64'd0);
        ir = 1'b1;
        for (int n = 0; n < 20 && (n_in - in0) < 10; n++) begin
            cyc();
            if (acc) begin a = $urandom; b = $urandom; sub = ~sub; end
        end
        drain();
        chk("t4_in", 64'(n_in - in0), 64'd10);
        chk("t4_io", 64'(n_out - out0), 64'(n_in - in0));

        // Async reset with 3 ops in flight.
        for (int i = 0; i < 3; i++) begin
            a = 32'h1111_1111 * (i + 1); b = 32'h0F0F_0F0F; iv = 1'b1;
            cyc();
        end
        iv = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_ov", 64'(ov), 64'd0);
        chk("t5_s", 64'(s), 64'd0);
        chk("t5_c", 64'(co), 64'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            if (ov) stale++;
            cyc();
        end
        chk("t5_stale", 64'(stale), 64'd0);

        // Flush: simultaneous input is dropped; outputs keep last values.
        run1("t6pre", 32'h00FF_00FF, 32'h0001_0F01, 1'b0, 1'b0, 32'h0100_1000, 1'b0, 1'b0);
        a = 32'h1234_5678; b = 32'h1; iv = 1'b1; clr = 1'b1;
        cyc();
        clr = 1'b0; iv = 1'b0;
        chk("t6_ov", 64'(ov), 64'd0);
        chk("t6_rdy", 64'(rdy), 64'd1);
        chk("t6_hold_s", 64'(s), 64'h0100_1000);
        for (int i = 0; i < 2; i++) begin
            a = $urandom; b = $urandom; iv = 1'b1;
            cyc();
        end
        iv = 1'b0; clr = 1'b1;
        cyc();
        clr = 1'b0;
        q.delete();
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            if (ov) stale++;
            cyc();
        end
        chk("t6_stale", 64'(stale), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
